// File: rtl/hk_pkg.sv
// Shared types and default timeouts for the housekeeping SPI arbiter.
// The state type is used by hk_spi_arb; the constants are its default timeout limits.
package hk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BSY,
        ST_RUN,
        ST_DONE
    } hk_state_e;

    localparam int HK_STA_TMO = 8;
    localparam int HK_RUN_TMO = 20000;

endpackage

// File: rtl/hk_rr_arb.sv
// NR-way round-robin arbiter producing a one-hot grant.
// The last-granted pointer advances only when the grant is accepted.
module hk_rr_arb #(
    parameter int NR = 2
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [NR-1:0] req_i,
    input  logic          accept_i,
    output logic [NR-1:0] gnt_o
);

    localparam int PW = (NR > 1) ? $clog2(NR) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;

    // Search starts one past the last grant and wraps, so the pointer itself is checked last.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 1; i <= NR; i++) begin
            for (int j = 0; j < NR; j++) begin
                if (!found && (j == ((int'(ptr_q) + i) % NR)) && req_i[j]) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int j = 0; j < NR; j++) begin
            if (gnt_o[j]) begin
                ptr_d = PW'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q <= PW'(NR - 1);
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hk_spi_arb.sv
// Shares one spi_master between NR requesters with round-robin grant,
// start/run timeouts and registered completion/error pulses.
module hk_spi_arb
    import hk_pkg::*;
#(
    parameter int NR      = 2,
    parameter int TMO_W   = 16,
    parameter int STA_TMO = HK_STA_TMO,
    parameter int RUN_TMO = HK_RUN_TMO
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [NR-1:0]    req_i,
    input  logic [NR*16-1:0] wr_h_i,
    input  logic [NR*16-1:0] wr_l_i,
    output logic [NR-1:0]    gnt_o,
    output logic [NR-1:0]    done_o,
    output logic [NR-1:0]    err_o,
    output logic [15:0]      rd_o,
    output logic             spi_start_o,
    output logic [15:0]      spi_wr_h_o,
    output logic [15:0]      spi_wr_l_o,
    input  logic [15:0]      spi_rd_l_i,
    input  logic             spi_bsy_i
);

    localparam logic [TMO_W-1:0] STA_LAST = TMO_W'(STA_TMO - 1);
    localparam logic [TMO_W-1:0] RUN_LAST = TMO_W'(RUN_TMO - 1);

    hk_state_e        state_q;
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_inc;
    logic [NR-1:0]    gnt_q, done_q, err_q;
    logic             start_q;
    logic [15:0]      rd_q, wrh_q, wrl_q;
    logic [NR-1:0]    arb_gnt;
    logic             accept;
    logic [15:0]      sel_h, sel_l;

    assign accept  = (state_q == ST_IDLE) && (|req_i);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    hk_rr_arb #(.NR(NR)) u_rr_arb (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .req_i    (req_i),
        .accept_i (accept),
        .gnt_o    (arb_gnt)
    );

    always_comb begin
        sel_h = '0;
        sel_l = '0;
        for (int j = 0; j < NR; j++) begin
            if (arb_gnt[j]) begin
                sel_h = wr_h_i[16*j +: 16];
                sel_l = wr_l_i[16*j +: 16];
            end
        end
    end

    // The start pulse is registered out of START, so it appears two cycles after acceptance.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            rd_q    <= '0;
            wrh_q   <= '0;
            wrl_q   <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_q   <= arb_gnt;
                        wrh_q   <= sel_h;
                        wrl_q   <= sel_l;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    start_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_BSY;
                end
                ST_WAIT_BSY: begin
                    if (spi_bsy_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end else if (cnt_q == STA_LAST) begin
                        err_q   <= gnt_q;
                        gnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (!spi_bsy_i) begin
                        rd_q    <= spi_rd_l_i;
                        done_q  <= gnt_q;
                        state_q <= ST_DONE;
                    end else if (cnt_q == RUN_LAST) begin
                        err_q   <= gnt_q;
                        gnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_DONE: begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rd_o        = rd_q;
    assign spi_start_o = start_q;
    assign spi_wr_h_o  = wrh_q;
    assign spi_wr_l_o  = wrl_q;

endmodule

// File: tb/tb_hk_spi_arb.sv
// Scoreboard bench for hk_spi_arb: directed transactions push expected done/err pulses,
// a negedge monitor pops and compares them whenever the DUT pulses done_o or err_o.
module tb_hk_spi_arb;

    localparam int NR = 2;

    typedef struct packed {
        logic        isErr;
        logic [1:0]  vec;
        logic [15:0] rd;
    } expT;

    logic        clk;
    logic        rstn;
    logic [1:0]  req;
    logic [31:0] wrH, wrL;
    logic [1:0]  gnt, done, err;
    logic [15:0] rdO, spiWrH, spiWrL, spiRd;
    logic        spiStart, spiBsy;

    int          total = 0;
    int          bad = 0;
    int          startCount = 0;
    logic [15:0] lastRd = 16'h0000;
    expT         sb[$];

    hk_spi_arb #(.NR(NR)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_i       (req),
        .wr_h_i      (wrH),
        .wr_l_i      (wrL),
        .gnt_o       (gnt),
        .done_o      (done),
        .err_o       (err),
        .rd_o        (rdO),
        .spi_start_o (spiStart),
        .spi_wr_h_o  (spiWrH),
        .spi_wr_l_o  (spiWrL),
        .spi_rd_l_i  (spiRd),
        .spi_bsy_i   (spiBsy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [15:0] h0, input logic [15:0] l0,
                                 input logic [15:0] h1, input logic [15:0] l1);
        wrH = {h1, h0};
        wrL = {l1, l0};
        req = r;
    endtask

    task automatic pushExp(input logic isErr, input logic [1:0] vec, input logic [15:0] rd);
        expT e;
        e.isErr = isErr;
        e.vec   = vec;
        e.rd    = rd;
        sb.push_back(e);
        if (!isErr) lastRd = rd;
    endtask

    task automatic doReset();
        req    = 2'b00;
        spiBsy = 1'b0;
        rstn   = 1'b0;
        @(negedge clk);
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_done_err", 32'({done, err}), 32'h0);
        checkOutput("rst_start", 32'(spiStart), 32'h0);
        checkOutput("rst_rd", 32'(rdO), 32'h0);
        checkOutput("rst_wr", {spiWrH, spiWrL}, 32'h0);
        @(negedge clk);
        rstn   = 1'b1;
        lastRd = 16'h0000;
    endtask

    task automatic waitStart(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (spiStart) return;
        end
        n = -1;
    endtask

    // Spi_master model: busy rises the cycle after start, stays high busyLen cycles.
    task automatic bfmRun(input int busyLen, input logic [15:0] rdVal, input bit dropReq,
                          input logic [1:0] expVec);
        @(posedge clk);
        #1 spiBsy = 1'b1;
        for (int c = 0; c < busyLen - 1; c++) begin
            @(posedge clk);
            if (dropReq && c == 2) #1 req = 2'b00;
        end
        #1;
        spiBsy = 1'b0;
        spiRd  = rdVal;
        @(negedge clk);
        @(negedge clk);
        checkOutput("done_latency", 32'(done), 32'(expVec));
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (spiStart) startCount++;
            if ((done | err) != 2'b00) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", 32'({done, err}), 32'h0);
                end else begin
                    expT e;
                    e = sb.pop_front();
                    checkOutput("sb_done", 32'(done), e.isErr ? 32'h0 : 32'(e.vec));
                    checkOutput("sb_err", 32'(err), e.isErr ? 32'(e.vec) : 32'h0);
                    checkOutput("sb_rd", 32'(rdO), 32'(e.rd));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int base;
        logic [1:0] expSeq [3];
        expSeq[0] = 2'b01;
        expSeq[1] = 2'b10;
        expSeq[2] = 2'b01;
        spiRd = 16'h0000;
        applyStimulus(2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        doReset();

        // Single request with latency and latch-once checks.
        @(posedge clk);
        #1 applyStimulus(2'b01, 16'h8012, 16'h0000, 16'h0000, 16'h0000);
        pushExp(1'b0, 2'b01, 16'h00A5);
        waitStart(n);
        checkOutput("start_latency", 32'(n), 32'd3);
        checkOutput("single_gnt", 32'(gnt), 32'h1);
        wrH = 32'h0000_FFFF;
        bfmRun(100, 16'h00A5, 1'b0, 2'b01);
        req = 2'b00;
        checkOutput("single_wrh", 32'(spiWrH), 32'h8012);
        checkOutput("single_wrl", 32'(spiWrL), 32'h0000);
        repeat (3) @(negedge clk);
        checkOutput("single_rd_hold", 32'(rdO), 32'h00A5);
        checkOutput("single_starts", 32'(startCount), 32'd1);
        checkOutput("single_gnt_drop", 32'(gnt), 32'h0);

        // Contention from reset: grants alternate 01, 10, 01.
        doReset();
        base = startCount;
        @(posedge clk);
        #1 applyStimulus(2'b11, 16'h1111, 16'hAAAA, 16'h2222, 16'h5555);
        for (int k = 0; k < 3; k++) begin
            waitStart(n);
            checkOutput("cont_start_seen", 32'(n > 0), 32'h1);
            checkOutput("cont_gnt", 32'(gnt), 32'(expSeq[k]));
            checkOutput("cont_wrh", 32'(spiWrH), (expSeq[k] == 2'b01) ? 32'h1111 : 32'h2222);
            checkOutput("cont_wrl", 32'(spiWrL), (expSeq[k] == 2'b01) ? 32'hAAAA : 32'h5555);
            pushExp(1'b0, expSeq[k], 16'h1000 + 16'(k));
            bfmRun(5, 16'h1000 + 16'(k), 1'b0, expSeq[k]);
            if (k == 2) req = 2'b00;
            checkOutput("cont_starts", 32'(startCount - base), 32'(k + 1));
        end

        // Start timeout: busy never rises.
        repeat (2) @(negedge clk);
        applyStimulus(2'b01, 16'h0A0A, 16'h0B0B, 16'h0, 16'h0);
        pushExp(1'b1, 2'b01, lastRd);
        waitStart(n);
        n = 0;
        while (n < 20 && err == 2'b00) begin
            @(negedge clk);
            n++;
        end
        req = 2'b00;
        checkOutput("sta_tmo_cycles", 32'(n), 32'd8);
        base = startCount;
        repeat (5) @(negedge clk);
        checkOutput("sta_tmo_idle_gnt", 32'(gnt), 32'h0);
        checkOutput("sta_tmo_no_restart", 32'(startCount), 32'(base));

        // Run timeout: busy stuck high, then a normal transaction.
        applyStimulus(2'b10, 16'h0, 16'h0, 16'hC0DE, 16'h0001);
        pushExp(1'b1, 2'b10, lastRd);
        waitStart(n);
        @(posedge clk);
        #1 spiBsy = 1'b1;
        @(negedge clk);
        n = 1;
        while (n < 25000 && err == 2'b00) begin
            @(negedge clk);
            n++;
        end
        req    = 2'b00;
        spiBsy = 1'b0;
        checkOutput("run_tmo_cycles", 32'(n), 32'd20002);
        @(negedge clk);
        applyStimulus(2'b01, 16'h4321, 16'h8765, 16'h0, 16'h0);
        pushExp(1'b0, 2'b01, 16'h5A5A);
        waitStart(n);
        checkOutput("post_tmo_wrh", 32'(spiWrH), 32'h4321);
        bfmRun(10, 16'h5A5A, 1'b0, 2'b01);
        req = 2'b00;

        // Request dropped during RUN.
        repeat (2) @(negedge clk);
        applyStimulus(2'b10, 16'h0, 16'h0, 16'h3333, 16'h4444);
        pushExp(1'b0, 2'b10, 16'h3C3C);
        waitStart(n);
        bfmRun(8, 16'h3C3C, 1'b1, 2'b10);
        base = startCount;
        repeat (10) @(negedge clk);
        checkOutput("drop_no_restart", 32'(startCount), 32'(base));
        checkOutput("drop_gnt", 32'(gnt), 32'h0);

        // Async reset during RUN, then pointer restart at index 0.
        applyStimulus(2'b01, 16'hBEEF, 16'hCAFE, 16'h0, 16'h0);
        waitStart(n);
        @(posedge clk);
        #1 spiBsy = 1'b1;
        repeat (5) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        checkOutput("arst_gnt", 32'(gnt), 32'h0);
        checkOutput("arst_done_err", 32'({done, err}), 32'h0);
        checkOutput("arst_start", 32'(spiStart), 32'h0);
        checkOutput("arst_rd", 32'(rdO), 32'h0);
        checkOutput("arst_wr", {spiWrH, spiWrL}, 32'h0);
        spiBsy = 1'b0;
        req    = 2'b00;
        @(negedge clk);
        rstn   = 1'b1;
        lastRd = 16'h0000;
        @(posedge clk);
        #1 applyStimulus(2'b11, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
        waitStart(n);
        checkOutput("arst_first_gnt", 32'(gnt), 32'h1);
        pushExp(1'b0, 2'b01, 16'h7777);
        bfmRun(3, 16'h7777, 1'b0, 2'b01);
        req = 2'b00;

        repeat (5) @(negedge clk);
        checkOutput("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
